// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with request credit, PC-tag queue and in-order buffer toward decode
module fetch_unit #(
    parameter int PC_W  = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [15:0]     imem_rdata,
    output logic            op_valid,
    output logic [15:0]     op,
    output logic [PC_W-1:0] op_pc,
    input  logic            op_ready,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W:0] CAP = (CNT_W + 1)'(DEPTH);

    logic [PC_W-1:0]  fetch_pc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;
    logic [15:0]      buf_data [DEPTH];
    logic [PC_W-1:0]  buf_pc [DEPTH];
    logic [PC_W-1:0]  tag [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    tag_head;
    logic [PW-1:0]    tag_tail;
    logic             accept;
    logic             dropping;
    logic             write;
    logic             pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // credit check, handshake qualifiers and head-of-buffer outputs
    always_comb begin
        imem_req  = !rst && !redirect && (({1'b0, outstanding} + {1'b0, count}) < CAP);
        imem_addr = fetch_pc;
        accept    = imem_req && imem_gnt;
        dropping  = discard != '0;
        write     = imem_rvalid && !dropping && !redirect;
        op_valid  = count != '0;
        pop       = op_valid && op_ready && !redirect;
        op        = buf_data[head];
        op_pc     = buf_pc[head];
    end

    // fetch PC, in-flight and occupancy counters; a redirect turns everything still in flight into discards
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= '0;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
        end else begin
            outstanding <= outstanding + CNT_W'(accept) - CNT_W'(imem_rvalid);
            if (redirect) begin
                fetch_pc <= redirect_pc;
                discard  <= outstanding - CNT_W'(imem_rvalid);
                count    <= '0;
            end else begin
                if (accept) fetch_pc <= fetch_pc + PC_W'(1);
                if (imem_rvalid && dropping) discard <= discard - CNT_W'(1);
                count <= count + CNT_W'(write) - CNT_W'(pop);
            end
        end
    end

    // instruction buffer: kept responses enter at the tail, decode pops the head, redirect empties it
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else if (redirect) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (write) begin
                buf_data[tail] <= imem_rdata;
                buf_pc[tail]   <= tag[tag_head];
                tail           <= inc(tail);
            end
            if (pop) head <= inc(head);
        end
    end

    // PC tags of requests in flight; untouched by redirect so tags stay paired with their responses
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_head <= '0;
            tag_tail <= '0;
        end else begin
            if (accept) begin
                tag[tag_tail] <= fetch_pc;
                tag_tail      <= inc(tag_tail);
            end
            if (imem_rvalid) tag_head <= inc(tag_head);
        end
    end
endmodule
